enc_block_loader: RTL

ENC_BLOCK_LOADER -- requirements
Module: enc_block_loader

---
 rtl/enc_block_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/enc_block_loader.sv
// -----------------------------------------------------------------------------
// enc_block_loader
//
// Collects a 16-byte plaintext block from a valid/ready byte stream, hands it
// to the encryption stage together with six latched round-key bits, raises
// Enable until the stage reports finished, then pulses stage_rst for one cycle
// before accepting the next block.
//
// Optional build macro: LOADER_TIMEOUT_EN
//   When defined, a watchdog limits RUN to TIMEOUT_CYCLES cycles. On expiry the
//   block is abandoned through CLEAR and the sticky timeout_err flag is set.
//   When undefined, RUN waits for finished indefinitely and timeout_err is 0.
//
// Ports:
//   clk                input   single clock, rising edge
//   reset              input   synchronous, active-low
//   in_valid/in_data   input   offered plaintext byte (byte0..byte15 order)
//   in_ready           output  byte accepted this cycle when in_valid is high
//   key_in[5:0]        input   round-key bits [9:4], sampled with byte 15
//   a0..d3[7:0]        output  block bytes (0..3 -> a, 4..7 -> b, 8..11 -> c, 12..15 -> d)
//   key[5:0]           output  latched key bits
//   Enable             output  run request to the encryption stage
//   stage_rst          output  active-high reset to the encryption stage
//   finished           input   completion level from the encryption stage
//   block_done         output  one-cycle pulse per completed block
//   block_cnt[7:0]     output  completed-block count, wraps at 256
//   timeout_err        output  sticky watchdog flag
// -----------------------------------------------------------------------------
module enc_block_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic [5:0] key_in,
   output logic [7:0] a0,
   output logic [7:0] a1,
   output logic [7:0] a2,
   output logic [7:0] a3,
   output logic [7:0] b0,
   output logic [7:0] b1,
   output logic [7:0] b2,
   output logic [7:0] b3,
   output logic [7:0] c0,
   output logic [7:0] c1,
   output logic [7:0] c2,
   output logic [7:0] c3,
   output logic [7:0] d0,
   output logic [7:0] d1,
   output logic [7:0] d2,
   output logic [7:0] d3,
   output logic [5:0] key,
   output logic       Enable,
   output logic       stage_rst,
   input  logic       finished,
   output logic       block_done,
   output logic [7:0] block_cnt,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [3:0] idx_r;
   logic [7:0] blk_r [16];
   logic [5:0] key_r;
   logic       in_ready_r;
   logic       enable_r;
   logic       stage_rst_r;
   logic       block_done_r;
   logic [7:0] block_cnt_r;
   logic       accept_s;
   logic       done_s;
   logic       tmo_s;

   // in_ready_r is only set while in FILL, so it alone qualifies the handshake
   // and also blocks acceptance in the first cycle after reset.
   assign accept_s = (state_r == ST_FILL) && in_valid && in_ready_r;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            timeout_err_r;

   // Expiry fires in the last allowed RUN cycle; finished in that cycle still wins.
   assign tmo_s = (state_r == ST_RUN) && !finished && (wd_cnt_r == WD_LAST);

   // Watchdog counter (counts RUN cycles) and sticky error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt_r      <= '0;
         timeout_err_r <= 1'b0;
      end else begin
         if (state_r == ST_RUN) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
         end else begin
            wd_cnt_r <= '0;
         end
         if (tmo_s) begin
            timeout_err_r <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_err_r;
`else
   assign tmo_s       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next-state decode; block_done is raised only for a genuine completion.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (accept_s && (idx_r == 4'd15)) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_RUN: begin
            if (finished) begin
               state_s = ST_CLEAR;
               done_s  = 1'b1;
            end else if (tmo_s) begin
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_s = ST_FILL;
         end
         default: begin
            state_s = ST_FILL;
         end
      endcase
   end

   // State, byte index, key latch, completion count and registered controls.
   // Controls are decoded from the next state so they line up with state_r.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_FILL;
         idx_r        <= 4'd0;
         key_r        <= 6'd0;
         in_ready_r   <= 1'b0;
         enable_r     <= 1'b0;
         stage_rst_r  <= 1'b1;
         block_done_r <= 1'b0;
         block_cnt_r  <= 8'd0;
      end else begin
         state_r      <= state_s;
         in_ready_r   <= (state_s == ST_FILL);
         enable_r     <= (state_s == ST_RUN);
         stage_rst_r  <= (state_s == ST_CLEAR);
         block_done_r <= done_s;
         if (done_s) begin
            block_cnt_r <= block_cnt_r + 8'd1;
         end
         if (accept_s) begin
            idx_r <= idx_r + 4'd1;
            if (idx_r == 4'd15) begin
               key_r <= key_in;
            end
         end
      end
   end

   // Block byte storage; a partial block is wiped by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            blk_r[i] <= 8'h00;
         end
      end else if (accept_s) begin
         blk_r[idx_r] <= in_data;
      end
   end

   assign a0 = blk_r[0];
   assign a1 = blk_r[1];
   assign a2 = blk_r[2];
   assign a3 = blk_r[3];
   assign b0 = blk_r[4];
   assign b1 = blk_r[5];
   assign b2 = blk_r[6];
   assign b3 = blk_r[7];
   assign c0 = blk_r[8];
   assign c1 = blk_r[9];
   assign c2 = blk_r[10];
   assign c3 = blk_r[11];
   assign d0 = blk_r[12];
   assign d1 = blk_r[13];
   assign d2 = blk_r[14];
   assign d3 = blk_r[15];

   assign key        = key_r;
   assign in_ready   = in_ready_r;
   assign Enable     = enable_r;
   assign stage_rst  = stage_rst_r;
   assign block_done = block_done_r;
   assign block_cnt  = block_cnt_r;

endmodule
